// File: rtl/fast_ring_fetch.sv
// FAST ring fetch: reads the centre pixel and the 16 radius-3 circle pixels
// around (cx, cy) from a synchronous-read image SRAM and presents them in parallel.
module fast_ring_fetch #(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX       = 5,
  parameter int Y_MAX       = 5
) (
  input  logic                        ramclk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(X_MAX)-1:0]    cx,
  input  logic [$clog2(Y_MAX)-1:0]    cy,
  output logic [$clog2(X_MAX)-1:0]    x_addr,
  output logic [$clog2(Y_MAX)-1:0]    y_addr,
  output logic                        ren,
  input  logic [PIXEL_DEPTH-1:0]      rdat,
  output logic                        busy,
  output logic                        done,
  output logic                        ring_valid,
  output logic [PIXEL_DEPTH-1:0]      center_px,
  output logic [16*PIXEL_DEPTH-1:0]   ring_px
);

  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);
  localparam int XC = XW + 2;
  localparam int YC = YW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [4:0]              idx;
  logic [XW-1:0]           cx_q;
  logic [YW-1:0]           cy_q;
  logic                    accept;
  logic                    issuing;
  logic signed [XC-1:0]    x_sum;
  logic signed [YC-1:0]    y_sum;
  logic                    in_x, in_y;
  logic                    p_valid, p_inb;
  logic [4:0]              p_idx;
  logic [PIXEL_DEPTH-1:0]  center_q;
  logic [PIXEL_DEPTH-1:0]  ring_q [16];

  // Read index 0 is the centre; index k+1 is ring pixel k, clockwise from the top.
  function automatic int off_x(input logic [4:0] i);
    case (i)
      5'd2, 5'd8:               return 1;
      5'd3, 5'd7:               return 2;
      5'd4, 5'd5, 5'd6:         return 3;
      5'd10, 5'd16:             return -1;
      5'd11, 5'd15:             return -2;
      5'd12, 5'd13, 5'd14:      return -3;
      default:                  return 0;
    endcase
  endfunction

  function automatic int off_y(input logic [4:0] i);
    case (i)
      5'd1, 5'd2, 5'd16:        return -3;
      5'd3, 5'd15:              return -2;
      5'd4, 5'd14:              return -1;
      5'd6, 5'd12:              return 1;
      5'd7, 5'd11:              return 2;
      5'd8, 5'd9, 5'd10:        return 3;
      default:                  return 0;
    endcase
  endfunction

  assign accept  = start && (state == IDLE || state == DONE);
  assign issuing = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        busy = 1'b1;
        if (idx == 5'd16) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-bounds coordinates suppress the read and park the address at 0.
  always_comb begin
    x_sum  = XC'(int'(cx_q) + off_x(idx));
    y_sum  = YC'(int'(cy_q) + off_y(idx));
    in_x   = !x_sum[XC-1] && (int'(x_sum) <= X_MAX - 1);
    in_y   = !y_sum[YC-1] && (int'(y_sum) <= Y_MAX - 1);
    ren    = issuing && in_x && in_y;
    x_addr = ren ? x_sum[XW-1:0] : '0;
    y_addr = ren ? y_sum[YW-1:0] : '0;
  end

  always_ff @(posedge ramclk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cx_q  <= '0;
      cy_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx  <= '0;
        cx_q <= cx;
        cy_q <= cy;
      end else if (issuing && idx != 5'd16) begin
        idx <= idx + 5'd1;
      end
    end
  end

  // The in-bounds flag and index travel one stage behind the address so they
  // line up with the rdat they describe.
  always_ff @(posedge ramclk) begin
    if (rst) begin
      p_valid    <= 1'b0;
      p_inb      <= 1'b0;
      p_idx      <= '0;
      ring_valid <= 1'b0;
      center_q   <= '0;
      for (int k = 0; k < 16; k++) ring_q[k] <= '0;
    end else begin
      p_valid <= issuing;
      p_inb   <= ren;
      p_idx   <= idx;
      if (p_valid) begin
        if (p_idx == 5'd0) center_q <= p_inb ? rdat : '0;
        else               ring_q[4'(p_idx - 5'd1)] <= p_inb ? rdat : '0;
      end
      if (accept)              ring_valid <= 1'b0;
      else if (state == DRAIN) ring_valid <= 1'b1;
    end
  end

  assign center_px = center_q;

  for (genvar k = 0; k < 16; k++) begin : g_pack
    assign ring_px[k*PIXEL_DEPTH +: PIXEL_DEPTH] = ring_q[k];
  end

endmodule

// File: tb/tb_fast_ring_fetch.sv
// Bench for fast_ring_fetch: an 8x8 and a 5x5 instance share stimulus, each
// backed by an SRAM model holding pixel(x,y)=16*y+x; one is observed at a time.
module tb_fast_ring_fetch;

  logic         clk = 1'b0;
  logic         rst, start, sel5;
  logic [2:0]   cx, cy;

  logic [2:0]   xa8, ya8, xa5, ya5;
  logic         ren8, ren5, busy8, busy5, done8, done5, rv8, rv5;
  logic [7:0]   rdat8, rdat5, center8, center5;
  logic [127:0] ring8, ring5;

  logic [2:0]   o_x, o_y;
  logic         o_ren, o_busy, o_done, o_rv;
  logic [7:0]   o_center;
  logic [127:0] o_ring;

  int n_checks = 0;
  int n_pass   = 0;

  // Ring offsets, clockwise from the top.
  int dxs [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int dys [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  typedef struct packed {
    logic [2:0]      cx;
    logic [2:0]      cy;
    logic            s5;
    logic [7:0]      exp_center;
    logic [5:0][3:0] kidx;
    logic [5:0][7:0] kval;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  fast_ring_fetch #(.PIXEL_DEPTH(8), .X_MAX(8), .Y_MAX(8)) dut8 (
    .ramclk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy),
    .x_addr(xa8), .y_addr(ya8), .ren(ren8), .rdat(rdat8),
    .busy(busy8), .done(done8), .ring_valid(rv8),
    .center_px(center8), .ring_px(ring8)
  );

  fast_ring_fetch #(.PIXEL_DEPTH(8), .X_MAX(5), .Y_MAX(5)) dut5 (
    .ramclk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy),
    .x_addr(xa5), .y_addr(ya5), .ren(ren5), .rdat(rdat5),
    .busy(busy5), .done(done5), .ring_valid(rv5),
    .center_px(center5), .ring_px(ring5)
  );

  // Unread cycles return noise so that unforced out-of-bounds captures show up.
  always @(posedge clk) begin
    rdat8 <= ren8 ? 8'(16 * int'(ya8) + int'(xa8)) : 8'($urandom);
    rdat5 <= ren5 ? 8'(16 * int'(ya5) + int'(xa5)) : 8'($urandom);
  end

  assign o_x      = sel5 ? xa5     : xa8;
  assign o_y      = sel5 ? ya5     : ya8;
  assign o_ren    = sel5 ? ren5    : ren8;
  assign o_busy   = sel5 ? busy5   : busy8;
  assign o_done   = sel5 ? done5   : done8;
  assign o_rv     = sel5 ? rv5     : rv8;
  assign o_center = sel5 ? center5 : center8;
  assign o_ring   = sel5 ? ring5   : ring8;

  function automatic void model_read(input int cxi, input int cyi, input int i,
                                     input int maxv, output logic r,
                                     output int xa, output int ya,
                                     output logic [7:0] px);
    int x, y;
    x  = cxi + ((i == 0) ? 0 : dxs[i-1]);
    y  = cyi + ((i == 0) ? 0 : dys[i-1]);
    r  = (x >= 0) && (x < maxv) && (y >= 0) && (y < maxv);
    xa = r ? x : 0;
    ya = r ? y : 0;
    px = r ? 8'(16 * y + x) : 8'h00;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input int cxi, input int cyi, input logic s5);
    sel5 = s5;
    @(negedge clk);
    cx    = 3'(cxi);
    cy    = 3'(cyi);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Start a fetch and compare every address cycle and the final result with the model.
  task automatic fetch_and_check(input int cxi, input int cyi, input logic s5);
    int maxv;
    logic r;
    int xa, ya;
    logic [7:0] px, exp_c;
    logic [127:0] exp_ring;
    maxv = s5 ? 5 : 8;
    exp_ring = '0;
    applyStimulus(cxi, cyi, s5);
    checkOutput("rv_cleared_on_start", 128'(o_rv), 128'(0));
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      model_read(cxi, cyi, i, maxv, r, xa, ya, px);
      checkOutput($sformatf("read%0d_ren_addr", i),
                  128'({o_busy, o_ren, o_x, o_y}),
                  128'({1'b1, r, 3'(xa), 3'(ya)}));
      if (i == 0) exp_c = px;
      else        exp_ring[(i-1)*8 +: 8] = px;
    end
    @(posedge clk);
    #1 checkOutput("drain_busy_done", 128'({o_busy, o_done}), 128'(2'b10));
    @(posedge clk);
    #1 checkOutput("done_busy_rv", 128'({o_busy, o_done, o_rv}), 128'(3'b011));
    checkOutput("center_model", 128'(o_center), 128'(exp_c));
    checkOutput("ring_model", o_ring, exp_ring);
  endtask

  task automatic check_all_zero(input string name);
    checkOutput(name, 128'({o_busy, o_done, o_rv, o_ren, o_x, o_y, o_center}), 128'(0));
    checkOutput({name, "_ring"}, o_ring, 128'(0));
  endtask

  initial begin
    int first_done, second_done, done_seen;

    vecs[0] = '{cx: 3'd3, cy: 3'd3, s5: 1'b0, exp_center: 8'h33,
                kidx: {4'd6, 4'd2, 4'd12, 4'd8, 4'd4, 4'd0},
                kval: {8'h55, 8'h15, 8'h30, 8'h63, 8'h36, 8'h03}};
    vecs[1] = '{cx: 3'd0, cy: 3'd0, s5: 1'b0, exp_center: 8'h00,
                kidx: {4'd14, 4'd12, 4'd0, 4'd6, 4'd8, 4'd4},
                kval: {8'h00, 8'h00, 8'h00, 8'h22, 8'h30, 8'h03}};
    vecs[2] = '{cx: 3'd7, cy: 3'd7, s5: 1'b1, exp_center: 8'h00,
                kidx: {4'd15, 4'd12, 4'd9, 4'd6, 4'd3, 4'd0},
                kval: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

    rst = 1'b1; start = 1'b0; cx = '0; cy = '0; sel5 = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_8x8");
    sel5 = 1'b1;
    #1 check_all_zero("reset_5x5");
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      fetch_and_check(int'(vecs[v].cx), int'(vecs[v].cy), vecs[v].s5);
      checkOutput($sformatf("vec%0d_center", v), 128'(o_center), 128'(vecs[v].exp_center));
      for (int j = 0; j < 6; j++)
        checkOutput($sformatf("vec%0d_ring%0d", v, vecs[v].kidx[j]),
                    128'(o_ring[int'(vecs[v].kidx[j])*8 +: 8]), 128'(vecs[v].kval[j]));
      @(posedge clk);
      #1 checkOutput($sformatf("vec%0d_rv_hold", v), 128'({o_done, o_rv}), 128'(2'b01));
    end

    for (int n = 0; n < 8; n++)
      fetch_and_check(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'(n % 2));

    // start held high: the second request is taken in the DONE cycle.
    sel5 = 1'b0;
    first_done  = -1;
    second_done = -1;
    @(negedge clk);
    cx = 3'd3; cy = 3'd3; start = 1'b1;
    @(posedge clk);
    #1 begin cx = 3'd4; cy = 3'd4; end
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (c == 5)
        checkOutput("b2b_ignore_busy_start", 128'({o_ren, o_x, o_y}),
                    128'({1'b1, 3'd6, 3'd3}));
      if (o_done) begin
        if (first_done < 0) begin
          first_done = c;
          checkOutput("b2b_first_center", 128'(o_center), 128'(8'h33));
        end else begin
          second_done = c;
          checkOutput("b2b_second_center", 128'(o_center), 128'(8'h44));
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b_first_latency", 128'(first_done), 128'(18));
    checkOutput("b2b_second_done", 128'(second_done), 128'(37));

    // Reset five cycles into a fetch aborts it and clears the held result.
    applyStimulus(3, 3, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check_all_zero("rst_mid_fetch");
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1 if (o_done || o_busy) done_seen++;
    end
    checkOutput("no_activity_after_rst", 128'(done_seen), 128'(0));

    // start coinciding with reset is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; cx = 3'd2; cy = 3'd2;
    @(posedge clk);
    #1 checkOutput("rst_beats_start", 128'({o_busy, o_rv}), 128'(0));
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    @(posedge clk);
    #1 checkOutput("idle_after_rst_start", 128'(o_busy), 128'(0));

    fetch_and_check(3, 3, 1'b0);
    checkOutput("post_rst_center", 128'(o_center), 128'(8'h33));

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
